// File: rtl/cpu_pkg.sv
// cpu_pkg: mode-bus encodings, PC width and interrupt vector layout shared by
// mode_ctrl, the flag register file and the decode stage.
package cpu_pkg;
   localparam logic [1:0] MODE_BOOT    = 2'b00;
   localparam logic [1:0] MODE_USER    = 2'b01;
   localparam logic [1:0] MODE_HANDLER = 2'b10;
   localparam int PC_W = 16;
   localparam logic [PC_W-1:0] VEC_BASE = 16'hFF00;
   localparam int VEC_STRIDE = 4;
   typedef enum logic [1:0] {
      BOOT    = MODE_BOOT,
      USER    = MODE_USER,
      HANDLER = MODE_HANDLER
   } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
module irq_prio_enc #(
   parameter int NUM_IRQ = 4
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [2:0]         idx
);
   always_comb begin
      valid = |req;
      idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (req[i]) idx = 3'(i);
   end
endmodule

// File: rtl/mode_ctrl.sv
// mode_ctrl: processor mode sequencer and non-nesting interrupt controller;
// drives the mode bus, fetch redirects and the saved return PC.
module mode_ctrl #(
   parameter int NUM_IRQ = 4,
   parameter int PC_W = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0] VEC_BASE = cpu_pkg::VEC_BASE,
   parameter int VEC_STRIDE = cpu_pkg::VEC_STRIDE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               retire,
   input  logic               reti,
   input  logic [PC_W-1:0]    pc_next,
   output logic [1:0]         mode,
   output logic               redirect,
   output logic [PC_W-1:0]    redirect_pc,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [2:0]         active_irq,
   output logic [PC_W-1:0]    epc,
   output logic               bad_reti
);
   import cpu_pkg::*;
   state_t state, state_n;
   logic [NUM_IRQ-1:0] pending, pending_n, ack_n, req;
   logic valid, red_n, bad_n;
   logic [2:0] idx, act_n;
   logic [PC_W-1:0] vec, rpc_n, epc_n;
   assign req = pending & irq_mask;
   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (.req(req), .valid(valid), .idx(idx));
   assign vec = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(idx);
   assign mode = state;
   // new requests win over the clear of a source taken in the same cycle
   assign pending_n = (pending & ~ack_n) | irq;
   always_comb begin
      state_n = state;
      red_n = 1'b0;
      rpc_n = '0;
      ack_n = '0;
      act_n = active_irq;
      epc_n = epc;
      bad_n = 1'b0;
      if (halt) begin
         state_n = BOOT;
         act_n = '0;
      end else if (state == BOOT) begin
         if (start) state_n = USER;
      end else if (state == USER) begin
         bad_n = retire & reti;
         if (retire && valid) begin
            state_n = HANDLER;
            red_n = 1'b1;
            rpc_n = vec;
            ack_n = NUM_IRQ'(1) << idx;
            act_n = idx;
            epc_n = pc_next;
         end
      end else if (retire && reti) begin
         // handler exit always lands in USER for at least one cycle
         state_n = USER;
         red_n = 1'b1;
         rpc_n = epc;
         act_n = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pending <= '0;
         redirect <= 1'b0;
         redirect_pc <= '0;
         irq_ack <= '0;
         active_irq <= '0;
         epc <= '0;
         bad_reti <= 1'b0;
      end else begin
         state <= state_n;
         pending <= pending_n;
         redirect <= red_n;
         redirect_pc <= rpc_n;
         irq_ack <= ack_n;
         active_irq <= act_n;
         epc <= epc_n;
         bad_reti <= bad_n;
      end
   end
endmodule

// File: tb/tb_mode_ctrl.sv
// tb_mode_ctrl: scoreboard bench for mode_ctrl; each cycle pushes its expected
// registered outputs and each scenario task compares them against the DUT.
module tb_mode_ctrl;
   typedef struct packed {
      logic [1:0]  mode;
      logic        red;
      logic [15:0] rpc;
      logic [3:0]  ack;
      logic [2:0]  act;
      logic [15:0] epc;
      logic        bad;
   } out_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, halt = 1'b0, retire = 1'b0, reti = 1'b0;
   logic [3:0] irq = 4'hF, irq_mask = 4'hF;
   logic [15:0] pc_next = '0;
   logic [1:0] mode;
   logic redirect, bad_reti;
   logic [15:0] redirect_pc, epc;
   logic [3:0] irq_ack;
   logic [2:0] active_irq;
   out_t sb[$], obs[$];
   int tests = 0, failed = 0;

   always #5 clk = ~clk;

   mode_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .irq(irq), .irq_mask(irq_mask),
      .retire(retire), .reti(reti), .pc_next(pc_next), .mode(mode), .redirect(redirect),
      .redirect_pc(redirect_pc), .irq_ack(irq_ack), .active_irq(active_irq), .epc(epc),
      .bad_reti(bad_reti)
   );

   function automatic out_t mk(input logic [1:0] m, input logic r, input logic [15:0] p,
                               input logic [3:0] a, input logic [2:0] x, input logic [15:0] e,
                               input logic b);
      return '{mode: m, red: r, rpc: p, ack: a, act: x, epc: e, bad: b};
   endfunction

   function automatic out_t snap();
      return '{mode: mode, red: redirect, rpc: redirect_pc, ack: irq_ack, act: active_irq,
               epc: epc, bad: bad_reti};
   endfunction

   // drive one cycle of stimulus, queue its expectation, capture the result
   task automatic cyc(input logic s, input logic h, input logic [3:0] i, input logic [3:0] m,
                      input logic r, input logic t, input logic [15:0] p, input out_t e);
      start = s; halt = h; irq = i; irq_mask = m; retire = r; reti = t; pc_next = p;
      sb.push_back(e);
      @(posedge clk);
      #1;
      obs.push_back(snap());
   endtask

   task automatic test_reset();
      out_t e, o;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(mk(2'b00, 0, 16'h0, 4'h0, 0, 16'h0, 0));
      obs.push_back(snap());
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 0, 4'hF, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0, 0));
      // all four requests were captured; they drain lowest index first
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h1000 + 16'(k),
             mk(2'b10, 1, 16'hFF00 + 16'(4 * k), 4'(1 << k), 3'(k), 16'h1000 + 16'(k), 0));
         cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h2000,
             mk(2'b01, 1, 16'h1000 + 16'(k), 4'h0, 0, 16'h1000 + 16'(k), 0));
      end
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL reset[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_take();
      out_t e, o;
      cyc(0, 0, 4'b0100, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h1003, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0123, mk(2'b10, 1, 16'hFF08, 4'b0100, 2, 16'h0123, 0));
      cyc(0, 0, 4'h0, 4'hF, 0, 0, 16'h0, mk(2'b10, 0, 16'h0, 4'h0, 2, 16'h0123, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0123, 4'h0, 0, 16'h0123, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL take[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_mask();
      out_t e, o;
      cyc(0, 0, 4'b0110, 4'b1101, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0123, 0));
      cyc(0, 0, 4'h0, 4'b1101, 1, 0, 16'h0200, mk(2'b10, 1, 16'hFF08, 4'b0100, 2, 16'h0200, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0200, 4'h0, 0, 16'h0200, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0300, mk(2'b10, 1, 16'hFF04, 4'b0010, 1, 16'h0300, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0304, mk(2'b10, 0, 16'h0, 4'h0, 1, 16'h0300, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0300, 4'h0, 0, 16'h0300, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL mask[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_no_nesting();
      out_t e, o;
      cyc(0, 0, 4'b1000, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0300, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0400, mk(2'b10, 1, 16'hFF0C, 4'b1000, 3, 16'h0400, 0));
      cyc(0, 0, 4'b0001, 4'hF, 0, 0, 16'h0, mk(2'b10, 0, 16'h0, 4'h0, 3, 16'h0400, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0404, mk(2'b10, 0, 16'h0, 4'h0, 3, 16'h0400, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0400, 4'h0, 0, 16'h0400, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0500, mk(2'b10, 1, 16'hFF00, 4'b0001, 0, 16'h0500, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0500, 4'h0, 0, 16'h0500, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL nesting[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_bad_reti();
      out_t e, o;
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0600, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0500, 1));
      cyc(0, 0, 4'b0001, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0500, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0700, mk(2'b10, 1, 16'hFF00, 4'b0001, 0, 16'h0700, 1));
      cyc(0, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 1, 16'h0700, 4'h0, 0, 16'h0700, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL bad_reti[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_halt();
      out_t e, o;
      cyc(0, 0, 4'b0100, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0700, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0800, mk(2'b10, 1, 16'hFF08, 4'b0100, 2, 16'h0800, 0));
      cyc(0, 1, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b00, 0, 16'h0, 4'h0, 0, 16'h0800, 0));
      cyc(1, 1, 4'b0010, 4'hF, 0, 0, 16'h0, mk(2'b00, 0, 16'h0, 4'h0, 0, 16'h0800, 0));
      cyc(1, 0, 4'h0, 4'hF, 1, 1, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0800, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0900, mk(2'b10, 1, 16'hFF04, 4'b0010, 1, 16'h0900, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL halt[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      out_t e, o;
      cyc(0, 0, 4'b0001, 4'hF, 0, 0, 16'h0, mk(2'b10, 0, 16'h0, 4'h0, 1, 16'h0900, 0));
      irq = 4'h0;
      #3 rst = 1'b1;
      #1;
      sb.push_back(mk(2'b00, 0, 16'h0, 4'h0, 0, 16'h0, 0));
      obs.push_back(snap());
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 0, 4'h0, 4'hF, 0, 0, 16'h0, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0, 0));
      cyc(0, 0, 4'h0, 4'hF, 1, 0, 16'h0A00, mk(2'b01, 0, 16'h0, 4'h0, 0, 16'h0, 0));
      for (int n = 0; sb.size() > 0; n++) begin
         e = sb.pop_front(); o = obs.pop_front(); tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL reset_mid[%0d]: got %h expected %h", n, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_take();
      test_mask();
      test_no_nesting();
      test_bad_reti();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Processor mode sequencer and interrupt controller; drives the 2-bit mode bus consumed by the flag register file.
- Flag-register mode encoding: 00 = boot/halt, flags cleared; 01 = user; 10 = interrupt handler.
- Latches interrupt requests, selects one by fixed priority at an instruction-retire boundary, saves the return PC, redirects fetch to the handler vector, and returns to user mode on RETI.
- No nesting: one handler active at a time.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (1..8).
- PC_W, 16, program counter width.
- VEC_BASE, 16'hFF00, PC of the vector for irq 0.
- VEC_STRIDE, 4, PC distance between consecutive vectors.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave boot state; honoured only in BOOT
- halt  in  1  return to BOOT from any state
- irq  in  NUM_IRQ  request pulses, one bit per source
- irq_mask  in  NUM_IRQ  1 = source enabled
- retire  in  1  an instruction retires this cycle (safe point)
- reti  in  1  retiring instruction is RETI; qualified by retire
- pc_next  in  PC_W  PC of the instruction after the retiring one
- mode  out  2  00 BOOT, 01 USER, 10 HANDLER; never 11
- redirect  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  PC_W  target PC, valid while redirect=1
- irq_ack  out  NUM_IRQ  one-hot pulse when a source is taken
- active_irq  out  3  index of the source being serviced; 0 outside HANDLER
- epc  out  PC_W  saved return PC
- bad_reti  out  1  one-cycle pulse: RETI retired outside HANDLER

Behaviour:
- All outputs are registered.
- Reset values: mode=00; redirect=0; redirect_pc=0; irq_ack=0; active_irq=0; epc=0; bad_reti=0; pending=0.
- States: BOOT, USER, HANDLER. mode equals the state encoding.
- pending[i] sets on irq[i]=1, in every state including BOOT.
- pending[i] clears only when source i is taken. Set and clear of the same bit in the same cycle: set wins, so the bit stays 1.
- BOOT:
  - start=1 → USER next cycle.
  - retire and reti are ignored.
  - Pending bits are kept.
- USER:
  - Taking an interrupt: if retire=1 and (pending & irq_mask)!=0, take the lowest set index k.
  - Next cycle: state=HANDLER; mode=10; epc=pc_next; redirect=1; redirect_pc=VEC_BASE+k*VEC_STRIDE (PC_W-bit wrap); irq_ack[k]=1; active_irq=k; pending[k] cleared.
  - Total latency from the retire edge is 1 cycle.
  - retire with reti=1 in USER: bad_reti pulses next cycle; no other effect. The interrupt-take rule still applies in the same cycle.
  - A masked pending bit stays pending and is taken once unmasked.
- HANDLER:
  - Further pending bits accumulate; no preemption.
  - retire=1 with reti=1 → next cycle: state=USER; mode=01; redirect=1; redirect_pc=epc; active_irq=0.
  - The next interrupt can be taken no earlier than the first retire in USER. Every handler exit therefore gives the user mode at least one mode=01 cycle, which lets the flag block clear its handler flags.
- halt=1 in any state → BOOT next cycle with mode=00.
  - redirect is not asserted.
  - epc and pending are kept.
  - halt has priority over start, interrupt take, and RETI in the same cycle.
- redirect, irq_ack and bad_reti are high for exactly one cycle per event.
- Reset mid-handler: immediate BOOT, all outputs at reset values, pending lost.

Decomposition:
- Shared package (cpu_pkg): the mode encodings MODE_BOOT=2'b00, MODE_USER=2'b01, MODE_HANDLER=2'b10, shared with the flag block and the decode stage; PC_W; VEC_BASE; VEC_STRIDE.
- One sub-module: irq_prio_enc, a combinational NUM_IRQ-input lowest-index priority encoder with outputs valid and idx[2:0].
- Pending register, FSM, epc and output registers stay in mode_ctrl.

Test Plan:
- Reset with irq=4'b1111 asserted during reset → all outputs 0, mode=00. After release, start pulse → mode=01 one cycle later. pending=1111 captured, since irq still high.
- USER, irq=4'b0100 pulse, mask=4'b1111, retire with pc_next=16'h0123 → next cycle: mode=10, redirect=1, redirect_pc=16'hFF08, irq_ack=4'b0100, active_irq=2, epc=16'h0123.
- Pending 4'b0110, mask 4'b1101, retire → irq 2 taken with vector FF08. irq 1 remains pending; after mask→1111 and return to USER, the next retire takes irq 1 with vector FF04.
- HANDLER, irq0 pulse arrives, then retire+reti → mode=01, redirect_pc=epc. On the following retire, irq 0 is taken; mode=01 holds for at least one cycle between the two handlers.
- USER, retire+reti → bad_reti pulses one cycle; mode stays 01; no redirect.
- HANDLER, halt and retire+reti in the same cycle → mode=00, redirect=0. Then start → mode=01, epc unchanged.
